// File: rtl/max7219_display_driver.sv
// MAX7219 SPI display driver: power-up init sequence, then continuous refresh of
// snapshotted BCD digits while enabled, with optional leading-zero blanking.
module max7219_display_driver #(
  parameter int unsigned N_DIGITS = 6,
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [7:0]  DP_MASK  = 8'b0001_0100,
  parameter bit          LZB      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [3:0]              intensity,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    mosi,
  output logic                    cs_n,
  output logic                    sclk
);

  localparam int unsigned DIG_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_PULSE = CNT_W'(2 * CLK_DIV - 2);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FRAME} state_t;
  typedef enum logic [1:0] {PH_NONE, PH_LOW, PH_HIGH, PH_GAP} phase_t;

  state_t            state, state_d;
  phase_t            phase, phase_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [3:0]        bit_cnt, bit_cnt_d;
  logic [15:0]       shreg, shreg_d;
  logic [3:0]        widx, widx_d;
  logic [DIG_W-1:0]  snap_dig, snap_dig_d;
  logic [3:0]        snap_int, snap_int_d;
  logic [3:0]        last_int, last_int_d;
  logic              int_first, int_first_d;
  logic              cs_n_d, sclk_d, busy_d, frame_done_d;

  logic              start, take_snap, word_end, last_word;
  logic [15:0]       word;

  // Init words, word 3 carrying the live intensity.
  function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] inten);
    case (idx)
      4'd0:    init_word = 16'h0F00;
      4'd1:    init_word = {8'h0B, 8'(N_DIGITS - 1)};
      4'd2:    init_word = {8'h09, 8'((1 << N_DIGITS) - 1)};
      4'd3:    init_word = {12'h0A0, inten};
      default: init_word = 16'h0C01;
    endcase
  endfunction

  // Frame word idx; with_int shifts digits by one behind a leading intensity word.
  function automatic logic [15:0] frame_word(input logic [3:0] idx, input logic [DIG_W-1:0] dig,
                                             input logic [3:0] inten, input logic with_int);
    logic [3:0] di;
    logic [3:0] nib;
    logic       dp;
    logic       higher_nz;
    di        = with_int ? idx - 4'd1 : idx;
    nib       = 4'd0;
    dp        = 1'b0;
    higher_nz = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (4'(k) == di) begin
        nib = 4'(dig >> (4 * k));
        dp  = DP_MASK[3'(k)];
      end
      if (4'(k) > di && 4'(dig >> (4 * k)) != 4'd0) higher_nz = 1'b1;
    end
    if (LZB && di != 4'd0 && nib == 4'd0 && !higher_nz) nib = 4'hF;
    if (with_int && idx == 4'd0) frame_word = {12'h0A0, inten};
    else                         frame_word = {4'h0, di + 4'd1, dp, 3'b000, nib};
  endfunction

  assign mosi = shreg[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      phase      <= PH_NONE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      widx       <= '0;
      snap_dig   <= '0;
      snap_int   <= '0;
      last_int   <= '0;
      int_first  <= 1'b0;
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      widx       <= widx_d;
      snap_dig   <= snap_dig_d;
      snap_int   <= snap_int_d;
      last_int   <= last_int_d;
      int_first  <= int_first_d;
      cs_n       <= cs_n_d;
      sclk       <= sclk_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    cnt_d        = cnt + CNT_W'(1);
    bit_cnt_d    = bit_cnt;
    shreg_d      = shreg;
    widx_d       = widx;
    snap_dig_d   = snap_dig;
    snap_int_d   = snap_int;
    last_int_d   = last_int;
    int_first_d  = int_first;
    cs_n_d       = cs_n;
    sclk_d       = sclk;
    busy_d       = busy;
    frame_done_d = 1'b0;
    start        = 1'b0;
    take_snap    = 1'b0;
    word_end     = 1'b0;
    word         = '0;
    last_word    = (state == ST_INIT) ? (widx == 4'd4)
                 : (widx == (int_first ? 4'(N_DIGITS) : 4'(N_DIGITS - 1)));

    case (phase)
      PH_NONE: begin
        cnt_d = '0;
        if (state == ST_INIT) begin
          start = 1'b1;
          word  = init_word(widx, intensity);
        end else if (state == ST_IDLE && ena) begin
          take_snap = 1'b1;
        end
      end
      PH_LOW: begin
        if (cnt == HALF_LAST) begin
          sclk_d  = 1'b1;
          phase_d = PH_HIGH;
          cnt_d   = '0;
        end
      end
      PH_HIGH: begin
        if (cnt == HALF_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_cnt == 4'd0) begin
            cs_n_d  = 1'b1;
            shreg_d = '0;
            phase_d = PH_GAP;
          end else begin
            shreg_d   = {shreg[14:0], 1'b0};
            bit_cnt_d = bit_cnt - 4'd1;
            phase_d   = PH_LOW;
          end
        end
      end
      default: begin
        // frame_done lands on the last cycle of the final cs_n-high gap
        if (cnt == GAP_PULSE && state == ST_FRAME && last_word) frame_done_d = 1'b1;
        if (cnt == GAP_LAST) word_end = 1'b1;
      end
    endcase

    if (word_end) begin
      phase_d = PH_NONE;
      cnt_d   = '0;
      if (state == ST_INIT) begin
        if (last_word) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          widx_d = widx + 4'd1;
          start  = 1'b1;
          word   = init_word(widx + 4'd1, intensity);
          if (widx == 4'd2) last_int_d = intensity;
        end
      end else if (!last_word) begin
        widx_d = widx + 4'd1;
        start  = 1'b1;
        word   = frame_word(widx + 4'd1, snap_dig, snap_int, int_first);
      end else if (ena) begin
        take_snap = 1'b1;
      end else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end

    // Snapshot edge: the first word is built from the values being captured.
    if (take_snap) begin
      snap_dig_d  = digits;
      snap_int_d  = intensity;
      int_first_d = (intensity != last_int);
      last_int_d  = intensity;
      widx_d      = '0;
      state_d     = ST_FRAME;
      busy_d      = 1'b1;
      start       = 1'b1;
      word        = frame_word(4'd0, digits, intensity, intensity != last_int);
    end

    if (start) begin
      shreg_d   = word;
      cs_n_d    = 1'b0;
      sclk_d    = 1'b0;
      bit_cnt_d = 4'd15;
      phase_d   = PH_LOW;
      cnt_d     = '0;
    end
  end

endmodule

// File: tb/tb_max7219_display_driver.sv
// Bench for max7219_display_driver: decodes the SPI bus of a default and an LZB=1
// instance every cycle and checks words, timing and frame_done against a model.
module tb_max7219_display_driver;

  localparam int CD = 4;
  localparam logic [7:0] DP = 8'b0001_0100;

  typedef struct packed {
    logic [15:0] w;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [23:0] digits;
  logic [3:0]  intensity;
  logic        busy_a, fd_a, mosi_a, cs_n_a, sclk_a;
  logic        busy_b, fd_b, mosi_b, cs_n_b, sclk_b;

  always #5 clk = ~clk;

  max7219_display_driver #(.N_DIGITS(6), .CLK_DIV(CD), .DP_MASK(DP), .LZB(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .digits(digits), .intensity(intensity),
    .busy(busy_a), .frame_done(fd_a), .mosi(mosi_a), .cs_n(cs_n_a), .sclk(sclk_a));

  max7219_display_driver #(.N_DIGITS(6), .CLK_DIV(CD), .DP_MASK(DP), .LZB(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .digits(digits), .intensity(intensity),
    .busy(busy_b), .frame_done(fd_b), .mosi(mosi_b), .cs_n(cs_n_b), .sclk(sclk_b));

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [3:0]  mlast[2];
  logic [15:0] lit[7];

  // Bus decoder state per instance
  int          run_c[2], low_c[2], gap_c[2], bits_c[2];
  int          rises[2] = '{0, 0};
  int          falls[2] = '{0, 0};
  logic [15:0] sh[2];
  logic        pcs[2], psk[2], pmo[2];
  logic        fd_pend[2];

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int g, input logic [15:0] w, input logic last);
    exp_t e;
    e.w = w;
    e.last = last;
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_lit(input int g, input int n, input logic is_frame);
    for (int i = 0; i < n; i++) push(g, lit[i], is_frame && (i == n - 1));
  endtask

  // Expected frame from the display rules: optional intensity word, then digits 0..5.
  task automatic push_frame(input int g, input logic [23:0] d, input logic [3:0] inten);
    int hi;
    logic [3:0] nib;
    hi = -1;
    for (int i = 0; i < 6; i++) if (((d >> (4 * i)) & 24'hF) != 0) hi = i;
    if (inten != mlast[g]) begin
      push(g, {12'h0A0, inten}, 1'b0);
      mlast[g] = inten;
    end
    for (int i = 0; i < 6; i++) begin
      nib = 4'((d >> (4 * i)) & 24'hF);
      if (g == 1 && i > 0 && i > hi) nib = 4'hF;
      push(g, {4'h0, 4'(i + 1), DP[i], 3'b000, nib}, i == 5);
    end
  endtask

  task automatic mon_reset();
    for (int g = 0; g < 2; g++) begin
      run_c[g] = 0; low_c[g] = 0; gap_c[g] = 1000; bits_c[g] = 0; sh[g] = '0;
      pcs[g] = 1'b1; psk[g] = 1'b0; pmo[g] = 1'b0; fd_pend[g] = 1'b0;
    end
  endtask

  task automatic mon_step(input int g, input logic cs, input logic sk, input logic mo, input logic fd);
    exp_t e;
    bit   have;
    bit   exp_fd;
    if (!cs) begin
      if (pcs[g]) begin
        chk($sformatf("dut%0d_word_gap_min", g), int'(gap_c[g] >= 2 * CD), 1);
        chk($sformatf("dut%0d_sclk_at_cs_fall", g), int'(sk), 0);
        bits_c[g] = 0; low_c[g] = 1; run_c[g] = 1; sh[g] = '0;
        falls[g]++;
      end else begin
        low_c[g]++;
        if (sk != psk[g]) begin
          chk($sformatf("dut%0d_sclk_half_period", g), run_c[g], CD);
          if (sk) begin
            sh[g] = {sh[g][14:0], mo};
            bits_c[g]++;
          end
          run_c[g] = 1;
        end else begin
          run_c[g]++;
        end
        if (mo != pmo[g]) chk($sformatf("dut%0d_mosi_moves_on_sclk_fall", g), int'({psk[g], sk}), 2);
      end
    end else begin
      if (!pcs[g]) begin
        chk($sformatf("dut%0d_cs_low_len", g), low_c[g], 32 * CD);
        chk($sformatf("dut%0d_bits_per_word", g), bits_c[g], 16);
        have = (g == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) begin
          e = (g == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("dut%0d_word", g), int'(sh[g]), int'(e.w));
          fd_pend[g] = e.last;
        end else begin
          n_cmp++;
          n_err++;
          $display("FAIL dut%0d_unexpected_word: got 0x%04h, expected no word (cycle %0d)", g, sh[g], cyc);
          fd_pend[g] = 1'b0;
        end
        rises[g]++;
        gap_c[g] = 1;
      end else begin
        gap_c[g]++;
      end
      if (sk) chk($sformatf("dut%0d_sclk_idle_low", g), int'(sk), 0);
    end
    exp_fd = fd_pend[g] && cs && (gap_c[g] == 2 * CD);
    if (fd || exp_fd) begin
      chk($sformatf("dut%0d_frame_done", g), int'(fd), int'(exp_fd));
      if (exp_fd) fd_pend[g] = 1'b0;
    end
    pcs[g] = cs; psk[g] = sk; pmo[g] = mo;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      mon_reset();
    end else begin
      mon_step(0, cs_n_a, sclk_a, mosi_a, fd_a);
      mon_step(1, cs_n_b, sclk_b, mosi_b, fd_b);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      n++;
      if (!busy_a && !busy_b) break;
    end
  endtask

  task automatic wait_fd(output int at);
    bit found;
    found = 1'b0;
    at = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      tick();
      if (fd_a) begin
        found = 1'b1;
        at = cyc;
      end
    end
    chk("frame_done_within_bound", int'(found), 1);
  endtask

  task automatic push_init(input logic [3:0] inten);
    lit = '{16'h0F00, 16'h0B05, 16'h093F, {12'h0A0, inten}, 16'h0C01, 16'h0000, 16'h0000};
    push_lit(0, 5, 1'b0);
    push_lit(1, 5, 1'b0);
    mlast[0] = inten;
    mlast[1] = inten;
  endtask

  initial begin
    int n, t_prev, t_now, f0, f1, r0;
    bit found;

    rst_n = 1'b0; ena = 1'b0; digits = '0; intensity = 4'hF;
    mon_reset();
    repeat (3) tick();
    chk("reset_state_a", int'({cs_n_a, sclk_a, mosi_a, busy_a, fd_a}), 5'b10010);
    chk("reset_state_b", int'({cs_n_b, sclk_b, mosi_b, busy_b, fd_b}), 5'b10010);

    // Init: 5 words of 136 cycles each, busy falls right after the fifth
    push_init(4'hF);
    #2 rst_n = 1'b1;
    wait_idle(n);
    chk("init_cycles_to_idle", n, 5 * 34 * CD + 1);
    chk("init_words_all_seen", q0.size() + q1.size(), 0);

    // Frame 1 with literal expectations, then back-to-back frames
    digits = 24'h123456;
    lit = '{16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0582, 16'h0601, 16'h0000};
    push_lit(0, 6, 1'b1);
    push_lit(1, 6, 1'b1);
    ena = 1'b1;
    wait_fd(t_prev);
    push_frame(0, digits, intensity);
    push_frame(1, digits, intensity);
    tick();
    chk("busy_held_back_to_back", int'({busy_a, busy_b}), 3);

    // Intensity change mid-frame takes effect on the next frame only
    repeat (300) tick();
    intensity = 4'h3;
    wait_fd(t_now);
    chk("frame_period_6_words", t_now - t_prev, 6 * 34 * CD);
    t_prev = t_now;
    lit = '{16'h0A03, 16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0582, 16'h0601};
    push_lit(0, 7, 1'b1);
    push_lit(1, 7, 1'b1);
    mlast[0] = 4'h3;
    mlast[1] = 4'h3;
    wait_fd(t_now);
    chk("frame_period_7_words", t_now - t_prev, 7 * 34 * CD);
    push_frame(0, digits, intensity);
    push_frame(1, digits, intensity);

    // Leading-zero blanking patterns
    repeat (300) tick();
    digits = 24'h000007;
    wait_fd(t_now);
    push_frame(0, digits, intensity);
    lit = '{16'h0107, 16'h020F, 16'h038F, 16'h040F, 16'h058F, 16'h060F, 16'h0000};
    push_lit(1, 6, 1'b1);
    repeat (300) tick();
    digits = 24'h000000;
    wait_fd(t_now);
    push_frame(0, digits, intensity);
    lit = '{16'h0100, 16'h020F, 16'h038F, 16'h040F, 16'h058F, 16'h060F, 16'h0000};
    push_lit(1, 6, 1'b1);
    repeat (300) tick();
    digits = 24'hF0A0B0;
    wait_fd(t_now);
    push_frame(0, digits, intensity);
    push_frame(1, digits, intensity);

    // ena drops during word 3: frame completes, then the bus stays quiet
    repeat (300) tick();
    ena = 1'b0;
    wait_fd(t_now);
    tick();
    chk("busy_low_after_last_frame", int'({busy_a, busy_b}), 0);
    f0 = falls[0];
    f1 = falls[1];
    repeat (400) tick();
    chk("no_cs_activity_when_disabled_a", falls[0] - f0, 0);
    chk("no_cs_activity_when_disabled_b", falls[1] - f1, 0);
    chk("all_frame_words_seen", q0.size() + q1.size(), 0);

    // Asynchronous reset in the middle of a digit word
    push_frame(0, digits, intensity);
    push_frame(1, digits, intensity);
    r0 = rises[0];
    ena = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (rises[0] == r0 + 1 && bits_c[0] == 8 && sclk_a) found = 1'b1;
    end
    chk("reached_bit8_of_digit_word", int'(found), 1);
    #2 rst_n = 1'b0;
    ena = 1'b0;
    #1;
    chk("async_reset_a", int'({cs_n_a, sclk_a, mosi_a, busy_a, fd_a}), 5'b10010);
    chk("async_reset_b", int'({cs_n_b, sclk_b, mosi_b, busy_b, fd_b}), 5'b10010);
    q0.delete();
    q1.delete();
    intensity = 4'h7;
    repeat (3) tick();
    push_init(4'h7);
    #2 rst_n = 1'b1;
    wait_idle(n);
    chk("reinit_cycles_to_idle", n, 5 * 34 * CD + 1);
    chk("reinit_words_all_seen", q0.size() + q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/max7219_display_driver.md
Name: max7219_display_driver

Overview:
- Parametrised MAX7219 SPI display driver for the stopwatch and later clock designs; generalises the fixed 6-digit driver.
- Configurable digit count (1-8), SPI clock rate, decimal-point placement and optional leading-zero blanking.
- Runs a power-up init sequence, then continuously refreshes snapshotted BCD digits while enabled.
- Sits between the counter chain and uo_out[2:0].

Parameters:
N_DIGITS, 6, number of digits driven (1..8); digit 0 is rightmost, MAX7219 register 0x01.
CLK_DIV, 4, sclk half-period in clk cycles (>=1).
DP_MASK, 8'b0001_0100, bit i set: decimal point lit on digit i.
LZB, 0, 1 = blank leading zeros on digits N_DIGITS-1..1; digit 0 is never blanked.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  display enable; frames start only while high
digits  input  4*N_DIGITS  BCD digits, digit i at [4i+3:4i]
intensity  input  4  MAX7219 brightness 0x0..0xF
busy  output  1  high during init or a frame
frame_done  output  1  one-cycle pulse at the end of each frame
mosi  output  1  SPI data, MSB first
cs_n  output  1  SPI chip select / LOAD, active-low
sclk  output  1  SPI clock, mode 0

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-word):
  - cs_n=1, sclk=0, mosi=0, busy=1, frame_done=0; state INIT, word index 0.
  - After release, init starts on the first clk edge.
- Word transfer, 16 bits:
  - cs_n falls; bit 15 is on mosi with sclk=0.
  - Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; mosi changes only on the sclk falling edge or while cs_n falls.
  - After bit 0's high phase, sclk=0 and cs_n rises, latching the word. cs_n stays high for 2*CLK_DIV cycles before the next word.
  - Word period = 34*CLK_DIV clk cycles.
- INIT sends 5 words in order:
  - 0x0F00 (display test off)
  - 0x0B00|(N_DIGITS-1) (scan limit)
  - 0x0900|((1<<N_DIGITS)-1) (code-B decode)
  - 0x0A00|intensity, with intensity sampled at the start of this word and stored as last_int
  - 0x0C01 (normal operation)
  - Then go to IDLE with busy=0. INIT ignores ena.
- IDLE: when ena=1, latch digits and intensity into snapshot registers in the same cycle, set busy=1, go to FRAME.
- FRAME:
  - If the snapshot intensity != last_int, first send 0x0A0I and update last_int.
  - Then send one word per digit i=0..N_DIGITS-1: 0x(i+1)DD.
    - DD[3:0] = snapshot digit, or 0xF (blank) if LZB=1, the digit is 0, i>0, and all higher digits are 0.
    - DD[7] = DP_MASK[i]; DD[6:4] = 0.
  - Values 0xA-0xF pass through unchanged (code-B symbols: -, E, H, L, P, blank).
- End of frame: frame_done pulses for 1 cycle coincident with the end of the last cs_n-high gap.
  - If ena=1 on that cycle, the next frame's snapshot is taken on the same cycle (busy stays 1).
  - Otherwise go to IDLE with busy=0.
- ena falling mid-frame: the frame completes unaltered. Input changes mid-frame are ignored (snapshot only).
- Outputs are registered; no combinational path from inputs to mosi/cs_n/sclk.

Test Plan:
- Init: N_DIGITS=6, CLK_DIV=4, intensity=0xF, release rst_n -> words 0x0F00, 0x0B05, 0x093F, 0x0A0F, 0x0C01 decoded from the bus; each word 136 clk cycles; busy falls after word 5.
- Frame: digits=24'h123456, ena=1, defaults -> words 0x0106, 0x0205, 0x0384, 0x0403, 0x0582, 0x0601; frame_done pulses once; back-to-back frames continue while ena=1.
- Intensity: change intensity 0xF->0x3 mid-frame -> the current frame is unchanged; the next frame begins with 0x0A03; the following frame has no 0x0A word.
- LZB=1: digits=24'h000007 -> 0x0107, 0x020F, 0x038F, 0x040F, 0x058F, 0x060F. digits=24'h000000 -> digit 0 sends 0x0100.
- Reset mid-word: assert rst_n low at bit 8 of a digit word -> cs_n=1 and sclk=0 in the same cycle with no clock edge needed; on release the full init sequence restarts from 0x0F00.
- ena drop: ena low during word 3 -> words 4-6 are still sent, frame_done pulses, busy=0, and no further cs_n activity occurs.
